// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain
// Description : DEPTH-stage elastic pipeline with a combinational ready
//               chain, per-stage flush, global enable and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    input  logic [DEPTH-1:0]             flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_v;
    logic [DATA_W-1:0] r_d [DEPTH];

    logic [DEPTH:0]    w_rdy;
    logic [DEPTH-1:0]  w_v_in;
    logic [DATA_W-1:0] w_d_in [DEPTH];
    logic [c_OCC_W-1:0] w_cnt;

    // rdy[i] = !v[i] | rdy[i+1] unrolled: a stage can advance when any
    // stage at or after it is empty, or the consumer is taking the tail.
    assign w_rdy[DEPTH] = out_ready;
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
        assign w_rdy[gi] = out_ready | ~(&r_v[DEPTH-1:gi]);
    end

    // Incoming payload per stage; a payload flushed while leaving its
    // stage arrives invalid at its destination.
    always_comb begin
        w_v_in[0] = in_valid;
        w_d_in[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_v_in[i] = r_v[i-1] & ~flush[i-1];
            w_d_in[i] = r_d[i-1];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i] <= w_v_in[i];
                    if (w_v_in[i]) begin
                        r_d[i] <= w_d_in[i];
                    end
                end else begin
                    r_v[i] <= r_v[i] & ~flush[i];
                end
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + c_OCC_W'(r_v[i]);
        end
    end

    // in_ready is gated by arst so nothing looks acceptable during reset.
    assign in_ready  = w_rdy[0] & enable & ~arst;
    assign out_valid = r_v[DEPTH-1] & enable & ~flush[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = w_cnt;

endmodule
`default_nettype wire
